// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Sequences a single-cycle datapath. It holds the PC and decodes the branch, jump
//   and halt opcodes from the fetched instruction. It picks the next PC using the
//   ALU zero/msb flags. A run-control FSM (IDLE/RUN/HALT) produces commit, which the
//   top level ANDs into regwrite/memwrite. It also counts retired instructions.
//
// Parameters
//   RESET_PC   PC value loaded on reset
//   HALT_INST  instruction word that stops execution
//   CNT_W      width of inst_count
//
// Ports
//   clk         in   1      system clock, all state updates on posedge
//   reset       in   1      asynchronous, active-high reset
//   start       in   1      level, moves IDLE to RUN
//   stall       in   1      level, freezes pc/count for the cycle while in RUN
//   inst        in   32     instruction currently fetched at pc
//   zero        in   1      ALU zero flag, same cycle
//   msb         in   1      ALU result[31], same cycle
//   pc          out  32     instruction-memory address
//   commit      out  1      write-enable qualifier for regwrite/memwrite
//   running     out  1      state is RUN
//   halted      out  1      state is HALT
//   inst_count  out  CNT_W  number of committed instructions (saturating)
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h00400020,
  parameter logic [31:0] HALT_INST = 32'hFFFFFFFF,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic [31:0]      inst,
  input  logic             zero,
  input  logic             msb,
  output logic [31:0]      pc,
  output logic             commit,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] inst_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10,
    BAD  = 2'b11
  } state_t;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t      state;
  state_t      next_state;
  logic        advance;
  logic [31:0] pc4;
  logic [31:0] boff;
  logic [31:0] next_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Stall wins over halt detection. Only a non-halt, unstalled RUN cycle commits
  // and advances. The unused encoding falls back to IDLE.
  always_comb begin
    next_state = state;
    commit     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        if (!stall) begin
          if (inst == HALT_INST) begin
            next_state = HALT;
          end else begin
            commit  = 1'b1;
            advance = 1'b1;
          end
        end
      end
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  assign running = (state == RUN);
  assign halted  = (state == HALT);

  // Branch offsets are word offsets, so they are sign-extended and scaled by 4.
  // All additions wrap modulo 2^32.
  assign pc4  = pc + 32'd4;
  assign boff = {{14{inst[15]}}, inst[15:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    case (inst[31:26])
      OP_BEQ:  if (zero)          next_pc = pc4 + boff;
      OP_BNE:  if (!zero)         next_pc = pc4 + boff;
      OP_BGTZ: if (!zero && !msb) next_pc = pc4 + boff;
      OP_J:    next_pc = {pc4[31:28], inst[25:0], 2'b00};
      default: next_pc = pc4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      inst_count <= '0;
    end else if (advance) begin
      pc <= next_pc;
      if (inst_count != {CNT_W{1'b1}}) inst_count <= inst_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed bench for pc_sequencer with hand-computed expectations. A second
//   instance, with the reset PC at the top of the address space and a 2-bit
//   counter, covers PC wraparound and count saturation.
module tb_pc_sequencer;

  localparam logic [31:0] ADD  = 32'h00000020;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] inst = 32'h00000020;
  logic        zero = 1'b0;
  logic        msb = 1'b0;
  logic [31:0] pc;
  logic        commit, running, halted;
  logic [31:0] inst_count;

  logic        w_start = 1'b0;
  logic [31:0] w_pc;
  logic        w_commit, w_running, w_halted;
  logic [1:0]  w_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .inst(inst),
    .zero(zero), .msb(msb), .pc(pc), .commit(commit), .running(running),
    .halted(halted), .inst_count(inst_count)
  );

  pc_sequencer #(.RESET_PC(32'hFFFFFFFC), .CNT_W(2)) dut_wrap (
    .clk(clk), .reset(reset), .start(w_start), .stall(1'b0), .inst(ADD),
    .zero(1'b0), .msb(1'b0), .pc(w_pc), .commit(w_commit), .running(w_running),
    .halted(w_halted), .inst_count(w_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; stall = 1'b0; inst = ADD;
    tick(); tick();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h00400020) begin errors++; $display("[TB] FAIL reset_pc[%0d] got=%h exp=00400020", i, pc); end
      checks++; if (commit !== 1'b0) begin errors++; $display("[TB] FAIL reset_commit[%0d] got=%b exp=0", i, commit); end
      checks++; if (running !== 1'b0 || halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_state[%0d] got=%b%b exp=00", i, running, halted); end
      checks++; if (inst_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count[%0d] got=%0d exp=0", i, inst_count); end
    end
  endtask

  task automatic test_sequential;
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h00400024; exp_pc[1] = 32'h00400028; exp_pc[2] = 32'h0040002C;
    start = 1'b1; inst = ADD;
    tick();
    start = 1'b0;
    checks++; if (running !== 1'b1 || pc !== 32'h00400020) begin errors++; $display("[TB] FAIL start_edge got run=%b pc=%h exp run=1 pc=00400020", running, pc); end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (commit !== 1'b1) begin errors++; $display("[TB] FAIL add_commit[%0d] got=%b exp=1", i, commit); end
      tick();
      checks++; if (pc !== exp_pc[i]) begin errors++; $display("[TB] FAIL add_pc[%0d] got=%h exp=%h", i, pc, exp_pc[i]); end
    end
    checks++; if (inst_count !== 32'd3) begin errors++; $display("[TB] FAIL add_count got=%0d exp=3", inst_count); end
  endtask

  task automatic test_branch;
    logic [31:0] v_inst [9];
    logic        v_zero [9];
    logic        v_msb  [9];
    logic [31:0] v_pc   [9];
    v_inst[0] = ADD;          v_zero[0] = 0; v_msb[0] = 0; v_pc[0] = 32'h00400030;
    v_inst[1] = 32'h1000FFFE; v_zero[1] = 1; v_msb[1] = 0; v_pc[1] = 32'h0040002C;
    v_inst[2] = ADD;          v_zero[2] = 0; v_msb[2] = 0; v_pc[2] = 32'h00400030;
    v_inst[3] = 32'h1000FFFE; v_zero[3] = 0; v_msb[3] = 0; v_pc[3] = 32'h00400034;
    v_inst[4] = 32'h1000FFFE; v_zero[4] = 1; v_msb[4] = 0; v_pc[4] = 32'h00400030;
    v_inst[5] = 32'h1C00FFFE; v_zero[5] = 0; v_msb[5] = 1; v_pc[5] = 32'h00400034;
    v_inst[6] = 32'h1C00FFFE; v_zero[6] = 0; v_msb[6] = 0; v_pc[6] = 32'h00400030;
    v_inst[7] = 32'h1400FFFE; v_zero[7] = 0; v_msb[7] = 0; v_pc[7] = 32'h0040002C;
    v_inst[8] = 32'h1C00FFFE; v_zero[8] = 1; v_msb[8] = 0; v_pc[8] = 32'h00400030;
    for (int i = 0; i < 9; i++) begin
      inst = v_inst[i]; zero = v_zero[i]; msb = v_msb[i];
      tick();
      checks++; if (pc !== v_pc[i]) begin errors++; $display("[TB] FAIL branch_pc[%0d] got=%h exp=%h", i, pc, v_pc[i]); end
    end
    zero = 1'b0; msb = 1'b0;
    checks++; if (inst_count !== 32'd12) begin errors++; $display("[TB] FAIL branch_count got=%0d exp=12", inst_count); end
  endtask

  task automatic test_jump;
    inst = 32'h08100010;
    tick();
    checks++; if (pc !== 32'h00400040) begin errors++; $display("[TB] FAIL jump_pc got=%h exp=00400040", pc); end
    tick();
    checks++; if (pc !== 32'h00400040) begin errors++; $display("[TB] FAIL jump_self_pc got=%h exp=00400040", pc); end
    checks++; if (inst_count !== 32'd14) begin errors++; $display("[TB] FAIL jump_count got=%0d exp=14", inst_count); end
  endtask

  task automatic test_stall_halt;
    stall = 1'b1; inst = ADD;
    #1;
    checks++; if (commit !== 1'b0) begin errors++; $display("[TB] FAIL stall_add_commit got=%b exp=0", commit); end
    tick();
    checks++; if (pc !== 32'h00400040 || inst_count !== 32'd14) begin errors++; $display("[TB] FAIL stall_add_hold got pc=%h cnt=%0d exp pc=00400040 cnt=14", pc, inst_count); end
    inst = HALT;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (commit !== 1'b0) begin errors++; $display("[TB] FAIL stall_halt_commit[%0d] got=%b exp=0", i, commit); end
      tick();
      checks++; if (running !== 1'b1 || halted !== 1'b0) begin errors++; $display("[TB] FAIL stall_halt_state[%0d] got run=%b halt=%b exp run=1 halt=0", i, running, halted); end
      checks++; if (pc !== 32'h00400040 || inst_count !== 32'd14) begin errors++; $display("[TB] FAIL stall_halt_hold[%0d] got pc=%h cnt=%0d exp pc=00400040 cnt=14", i, pc, inst_count); end
    end
    stall = 1'b0;
    #1;
    checks++; if (commit !== 1'b0) begin errors++; $display("[TB] FAIL halt_commit got=%b exp=0", commit); end
    tick();
    checks++; if (halted !== 1'b1 || running !== 1'b0) begin errors++; $display("[TB] FAIL halt_state got halt=%b run=%b exp halt=1 run=0", halted, running); end
    checks++; if (pc !== 32'h00400040 || inst_count !== 32'd14) begin errors++; $display("[TB] FAIL halt_hold got pc=%h cnt=%0d exp pc=00400040 cnt=14", pc, inst_count); end
    start = 1'b1; inst = ADD;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (commit !== 1'b0) begin errors++; $display("[TB] FAIL halt_start_commit[%0d] got=%b exp=0", i, commit); end
      tick();
      checks++; if (halted !== 1'b1 || pc !== 32'h00400040) begin errors++; $display("[TB] FAIL halt_start_ignored[%0d] got halt=%b pc=%h exp halt=1 pc=00400040", i, halted, pc); end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1; inst = ADD;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++; if (pc !== 32'h00400028 || running !== 1'b1) begin errors++; $display("[TB] FAIL rerun_pc got=%h run=%b exp=00400028 run=1", pc, running); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (pc !== 32'h00400020) begin errors++; $display("[TB] FAIL async_reset_pc got=%h exp=00400020", pc); end
    checks++; if (commit !== 1'b0 || running !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_commit got commit=%b run=%b exp 0 0", commit, running); end
    checks++; if (inst_count !== 32'd0) begin errors++; $display("[TB] FAIL async_reset_count got=%0d exp=0", inst_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_wrap_saturate;
    logic [31:0] exp_pc  [4];
    logic [1:0]  exp_cnt [4];
    exp_pc[0] = 32'h00000000; exp_cnt[0] = 2'd1;
    exp_pc[1] = 32'h00000004; exp_cnt[1] = 2'd2;
    exp_pc[2] = 32'h00000008; exp_cnt[2] = 2'd3;
    exp_pc[3] = 32'h0000000C; exp_cnt[3] = 2'd3;
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    checks++; if (w_pc !== 32'hFFFFFFFC || w_running !== 1'b1) begin errors++; $display("[TB] FAIL wrap_start got pc=%h run=%b exp FFFFFFFC 1", w_pc, w_running); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (w_pc !== exp_pc[i]) begin errors++; $display("[TB] FAIL wrap_pc[%0d] got=%h exp=%h", i, w_pc, exp_pc[i]); end
      checks++; if (w_count !== exp_cnt[i]) begin errors++; $display("[TB] FAIL sat_count[%0d] got=%0d exp=%0d", i, w_count, exp_cnt[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall_halt();
    test_reset_mid_run();
    test_wrap_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
